// File: rtl/i2s_transmitter.sv
// Philips I2S output stage: one-sample input buffer with valid/read-done handshake,
// internal bclk/lrclk generation, and MSB-first serialization of the same sample to both slots.
module i2s_transmitter #(
  parameter int data_width = 16,
  parameter int bclk_div   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_read_done,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_underrun
);

  localparam int SLOTS = 2 * data_width;
  localparam int DIV_W = (bclk_div > 1) ? $clog2(bclk_div) : 1;
  localparam int BIT_W = $clog2(SLOTS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(bclk_div - 1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOTS - 1);
  localparam logic [BIT_W-1:0] SLOT_HALF = BIT_W'(data_width);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e            state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  read_done_q, read_done_d;
  logic                  underrun_q, underrun_d;
  logic [data_width-1:0] hold_q, hold_d;
  logic [data_width-1:0] shift_q, shift_d;

  logic                  div_tc;
  logic                  fall_strobe;
  logic                  load_pt;
  logic [data_width-1:0] load_word;
  logic [data_width-1:0] tx_src;

  assign div_tc      = (div_cnt_q == DIV_LAST);
  assign fall_strobe = div_tc & bclk_q;
  // Falling edge that leaves slot 0 and enters slot 1 (left MSB).
  assign load_pt     = fall_strobe & (bit_cnt_q == '0);

  // Bit clock, slot counter and word select.
  always_comb begin
    div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
    bclk_d    = div_tc ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    if (fall_strobe) begin
      bit_cnt_d = (bit_cnt_q == SLOT_LAST) ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (bit_cnt_d >= SLOT_HALF);
    end
  end

  // Input buffer FSM; the load point looks at the state before any same-cycle capture.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    read_done_d = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (i_data_valid) begin
          hold_d      = i_data;
          read_done_d = 1'b1;
          state_d     = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (load_pt) begin
          state_d = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // Underrun reloads the shift register, which is back in its original
  // orientation after a full frame of 2W rotations.
  assign load_word = (state_q == BUF_FULL) ? hold_q : shift_q;
  assign tx_src    = load_pt ? load_word : shift_q;

  // Rotate-left serializer: MSB goes out, so slot 0 naturally carries the previous LSB.
  always_comb begin
    shift_d    = shift_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    if (fall_strobe) begin
      sdata_d = tx_src[data_width-1];
      shift_d = {tx_src[data_width-2:0], tx_src[data_width-1]};
      if (load_pt && (state_q == BUF_EMPTY)) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BUF_EMPTY;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      read_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      read_done_q <= read_done_d;
      underrun_q  <= underrun_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
    end
  end

  assign o_read_done = read_done_q;
  assign o_bclk      = bclk_q;
  assign o_lrclk     = lrclk_q;
  assign o_sdata     = sdata_q;
  assign o_underrun  = underrun_q;

endmodule
